// File: rtl/usb_tx_packet_seq_pkg.sv
// Shared types and constants for the USB full-speed transmit packet sequencer.
package usb_pkg;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_DATA0 = 3'd1,
        PKT_DATA1 = 3'd2,
        PKT_ACK   = 3'd3,
        PKT_NAK   = 3'd4,
        PKT_STALL = 3'd5
    } tx_packet_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA_REQ,
        ST_DATA_WAIT,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_EOP,
        ST_DONE
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic logic code_is_valid(input logic [2:0] code);
        return (code >= 3'd1) && (code <= 3'd5);
    endfunction

    function automatic logic is_data_pkt(input tx_packet_t pkt);
        return (pkt == PKT_DATA0) || (pkt == PKT_DATA1);
    endfunction

    function automatic logic [7:0] pid_byte(input tx_packet_t pkt);
        case (pkt)
            PKT_DATA0: return PID_DATA0;
            PKT_DATA1: return PID_DATA1;
            PKT_ACK:   return PID_ACK;
            PKT_NAK:   return PID_NAK;
            PKT_STALL: return PID_STALL;
            default:   return 8'h00;
        endcase
    endfunction

    // Bits go out LSB-first, so the register is kept bit-reflected and shifts right.
    function automatic logic [15:0] crc16_byte_step(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] poly_refl;
        logic [15:0] c;
        for (int i = 0; i < 16; i++) poly_refl[i] = CRC16_POLY[15-i];
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ poly_refl;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_tx_packet_seq_if.sv
// Buffer-read and serializer-side handshake bundle of the TX packet sequencer.
interface usb_tx_packet_seq_if;
    logic       tx_start;
    logic [2:0] tx_packet;
    logic [6:0] buffer_occupancy;
    logic       get_tx_data;
    logic [7:0] tx_data;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       out_eop;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        input  tx_start, tx_packet, buffer_occupancy, tx_data, out_ready,
        output get_tx_data, out_byte, out_valid, out_eop, tx_busy, tx_done
    );

    modport slave (
        output tx_start, tx_packet, buffer_occupancy, tx_data, out_ready,
        input  get_tx_data, out_byte, out_valid, out_eop, tx_busy, tx_done
    );
endinterface

// File: rtl/usb_tx_packet_seq_crc16.sv
// USB CRC16 accumulator: one payload byte folded in per enabled cycle.
module usb_crc16_byte
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)       r_crc <= CRC16_INIT;
        else if (i_clear) r_crc <= CRC16_INIT;
        else if (i_en)    r_crc <= crc16_byte_step(r_crc, i_byte);
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/usb_tx_packet_seq.sv
// USB full-speed TX packet sequencer: SYNC, PID, payload, CRC16, then EOP request.
// state        | meaning
// IDLE         | waiting for a valid start
// SYNC / PID   | header bytes offered to the serializer
// DATA_REQ     | one-cycle buffer read; DATA_WAIT captures the byte; DATA offers it
// CRC_LO / HI  | complemented CRC bytes; EOP holds the request; DONE pulses tx_done
module usb_tx_packet_seq
    import usb_pkg::*;
#(
    parameter int MAX_BYTES = 64
) (
    input  logic                 clk,
    input  logic                 n_rst,
    usb_tx_packet_seq_if.master  tx_if
);

    state_t      r_state;
    tx_packet_t  r_packet;
    logic [6:0]  r_count;
    logic [7:0]  r_out_byte;
    logic        r_out_valid;
    logic        r_out_eop;
    logic        r_get_tx_data;
    logic        r_tx_busy;
    logic        r_tx_done;

    logic        w_accept;
    logic        w_xfer;
    logic [6:0]  w_count_init;
    logic [15:0] w_crc;

    assign w_accept     = (r_state == ST_IDLE) && tx_if.tx_start && code_is_valid(tx_if.tx_packet);
    assign w_xfer       = r_out_valid && tx_if.out_ready;
    assign w_count_init = (int'(tx_if.buffer_occupancy) > MAX_BYTES) ? 7'(MAX_BYTES)
                                                                     : tx_if.buffer_occupancy;

    usb_crc16_byte u_crc (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_clear (w_accept),
        .i_en    (r_state == ST_DATA_WAIT),
        .i_byte  (tx_if.tx_data),
        .o_crc   (w_crc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= ST_IDLE;
            r_packet      <= PKT_NONE;
            r_count       <= '0;
            r_out_byte    <= '0;
            r_out_valid   <= 1'b0;
            r_out_eop     <= 1'b0;
            r_get_tx_data <= 1'b0;
            r_tx_busy     <= 1'b0;
            r_tx_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_packet    <= tx_packet_t'(tx_if.tx_packet);
                    r_count     <= w_count_init;
                    r_out_byte  <= SYNC_BYTE;
                    r_out_valid <= 1'b1;
                    r_tx_busy   <= 1'b1;
                    r_state     <= ST_SYNC;
                end
                ST_SYNC: if (w_xfer) begin
                    r_out_byte <= pid_byte(r_packet);
                    r_state    <= ST_PID;
                end
                ST_PID, ST_DATA: if (w_xfer) begin
                    if ((r_state == ST_PID) && !is_data_pkt(r_packet)) begin
                        r_out_valid <= 1'b0;
                        r_out_eop   <= 1'b1;
                        r_state     <= ST_EOP;
                    end else if (r_count != 7'd0) begin
                        r_out_valid   <= 1'b0;
                        r_get_tx_data <= 1'b1;
                        r_state       <= ST_DATA_REQ;
                    end else begin
                        r_out_byte <= ~w_crc[7:0];
                        r_state    <= ST_CRC_LO;
                    end
                end
                ST_DATA_REQ: begin
                    r_get_tx_data <= 1'b0;
                    r_state       <= ST_DATA_WAIT;
                end
                ST_DATA_WAIT: begin
                    r_out_byte  <= tx_if.tx_data;
                    r_out_valid <= 1'b1;
                    r_count     <= r_count - 7'd1;
                    r_state     <= ST_DATA;
                end
                ST_CRC_LO: if (w_xfer) begin
                    r_out_byte <= ~w_crc[15:8];
                    r_state    <= ST_CRC_HI;
                end
                ST_CRC_HI: if (w_xfer) begin
                    r_out_valid <= 1'b0;
                    r_out_eop   <= 1'b1;
                    r_state     <= ST_EOP;
                end
                ST_EOP: if (tx_if.out_ready) begin
                    r_out_eop <= 1'b0;
                    r_tx_done <= 1'b1;
                    r_state   <= ST_DONE;
                end
                ST_DONE: begin
                    r_tx_done <= 1'b0;
                    r_tx_busy <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_if.out_byte    = r_out_byte;
    assign tx_if.out_valid   = r_out_valid;
    assign tx_if.out_eop     = r_out_eop;
    assign tx_if.get_tx_data = r_get_tx_data;
    assign tx_if.tx_busy     = r_tx_busy;
    assign tx_if.tx_done     = r_tx_done;

endmodule

// File: tb/tb_usb_tx_packet_seq.sv
// Directed bench for usb_tx_packet_seq: expected byte stream queued at start, checked on transfer.
module tb_usb_tx_packet_seq;

    localparam logic [8:0] EOP_MARK = 9'h100;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    usb_tx_packet_seq_if tx_if();

    usb_tx_packet_seq #(.MAX_BYTES(64)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .tx_if (tx_if.master)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [7:0] mem[128];
    int         get_cnt  = 0;
    int         done_cnt = 0;
    int         busy_cyc = 0;
    int         served   = 0;
    logic       stall_prev   = 1'b0;
    logic [7:0] stall_byte   = 8'h00;
    logic       eop_acc_prev = 1'b0;

    // Serializer-side monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!n_rst) begin
            stall_prev   = 1'b0;
            eop_acc_prev = 1'b0;
        end else begin
            if (tx_if.tx_busy === 1'b1)     busy_cyc++;
            if (tx_if.get_tx_data === 1'b1) get_cnt++;
            if (tx_if.tx_done === 1'b1)     done_cnt++;
            if (stall_prev) begin
                checks++;
                assert (tx_if.out_valid === 1'b1 && tx_if.out_byte === stall_byte) else begin
                    errors++;
                    $error("FAIL stall_stable: valid=%0b byte=%02h, expected valid=1 byte=%02h",
                           tx_if.out_valid, tx_if.out_byte, stall_byte);
                end
            end
            if (eop_acc_prev) begin
                checks++;
                assert (tx_if.tx_done === 1'b1) else begin
                    errors++;
                    $error("FAIL done_pulse: tx_done=%0b, expected 1", tx_if.tx_done);
                end
            end
            eop_acc_prev = 1'b0;
            if (tx_if.out_valid === 1'b1 && tx_if.out_ready === 1'b1) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_byte: got %02h, expected no transfer", tx_if.out_byte);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert ({1'b0, tx_if.out_byte} === e) else begin
                        errors++;
                        $error("FAIL out_byte: got %03h, expected %03h", {1'b0, tx_if.out_byte}, e);
                    end
                end
            end
            if (tx_if.out_eop === 1'b1 && tx_if.out_ready === 1'b1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
                checks++;
                assert (e === EOP_MARK && tx_if.out_valid === 1'b0) else begin
                    errors++;
                    $error("FAIL eop: got eop with valid=%0b pending=%03h, expected valid=0 pending=%03h",
                           tx_if.out_valid, e, EOP_MARK);
                end
                eop_acc_prev = 1'b1;
            end
            stall_prev = (tx_if.out_valid === 1'b1) && (tx_if.out_ready === 1'b0);
            stall_byte = tx_if.out_byte;
        end
    end

    // Buffer model: the byte for each read request appears the cycle after it.
    always @(posedge clk) begin
        #1;
        if (get_cnt != served) begin
            tx_if.tx_data = mem[served % 128];
            served++;
        end else begin
            tx_if.tx_data = 8'hEE;
        end
    end

    function automatic logic [15:0] golden_crc(input int base, input int k);
        logic [15:0] n;
        logic [15:0] r;
        logic        fb;
        logic [7:0]  b;
        n = 16'hFFFF;
        for (int j = 0; j < k; j++) begin
            b = mem[(base + j) % 128];
            for (int i = 0; i < 8; i++) begin
                fb = n[15] ^ b[i];
                n  = {n[14:0], 1'b0};
                if (fb) n = n ^ 16'h8005;
            end
        end
        for (int i = 0; i < 16; i++) r[i] = n[15-i];
        return ~r;
    endfunction

    task automatic push_expected(input logic [7:0] pid, input bit data, input int base, input int k);
        logic [15:0] crc;
        exp_q.push_back(9'h080);
        exp_q.push_back({1'b0, pid});
        if (data) begin
            for (int i = 0; i < k; i++) exp_q.push_back({1'b0, mem[(base + i) % 128]});
            crc = golden_crc(base, k);
            exp_q.push_back({1'b0, crc[7:0]});
            exp_q.push_back({1'b0, crc[15:8]});
        end
        exp_q.push_back(EOP_MARK);
    endtask

    task automatic start_strobe(input logic [2:0] code, input logic [6:0] occ);
        @(posedge clk); #1;
        tx_if.tx_packet        = code;
        tx_if.buffer_occupancy = occ;
        tx_if.tx_start         = 1'b1;
        @(posedge clk); #1;
        tx_if.tx_start = 1'b0;
    endtask

    task automatic run_pkt(input string tag, input logic [2:0] code, input logic [7:0] pid,
                           input bit data, input logic [6:0] occ, input int k,
                           input bit toggle, input int exp_busy, input int inject_at);
        int g0, d0, b0;
        g0 = get_cnt; d0 = done_cnt; b0 = busy_cyc;
        push_expected(pid, data, served, k);
        tx_if.out_ready = toggle ? 1'b0 : 1'b1;
        start_strobe(code, occ);
        @(negedge clk);
        checks++;
        assert (tx_if.out_valid === 1'b1 && tx_if.out_byte === 8'h80) else begin
            errors++;
            $error("FAIL %s_latency: valid=%0b byte=%02h, expected valid=1 byte=80",
                   tag, tx_if.out_valid, tx_if.out_byte);
        end
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            tx_if.out_ready = toggle ? i[0] : 1'b1;
            tx_if.tx_start  = (i == inject_at);
            tx_if.tx_packet = (i == inject_at) ? 3'd3 : code;
            if (done_cnt != d0) break;
        end
        tx_if.tx_start  = 1'b0;
        tx_if.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        assert (done_cnt - d0 === 1) else begin
            errors++;
            $error("FAIL %s_done: pulses=%0d, expected 1", tag, done_cnt - d0);
        end
        checks++;
        assert (get_cnt - g0 === k) else begin
            errors++;
            $error("FAIL %s_reads: got %0d, expected %0d", tag, get_cnt - g0, k);
        end
        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL %s_leftover: %0d bytes never sent, expected 0", tag, exp_q.size());
        end
        checks++;
        assert (tx_if.tx_busy === 1'b0) else begin
            errors++;
            $error("FAIL %s_idle: tx_busy=%0b, expected 0", tag, tx_if.tx_busy);
        end
        if (exp_busy >= 0) begin
            checks++;
            assert (busy_cyc - b0 === exp_busy) else begin
                errors++;
                $error("FAIL %s_cycles: busy %0d, expected %0d", tag, busy_cyc - b0, exp_busy);
            end
        end
        exp_q.delete();
    endtask

    task automatic ignored_start(input string tag, input logic [2:0] code);
        start_strobe(code, 7'd3);
        repeat (2) @(negedge clk);
        checks++;
        assert (tx_if.tx_busy === 1'b0 && tx_if.out_valid === 1'b0) else begin
            errors++;
            $error("FAIL %s: busy=%0b valid=%0b, expected busy=0 valid=0",
                   tag, tx_if.tx_busy, tx_if.out_valid);
        end
    endtask

    initial begin
        int g0, d0;
        bit found;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i);
        tx_if.tx_start         = 1'b0;
        tx_if.tx_packet        = 3'd0;
        tx_if.buffer_occupancy = 7'd0;
        tx_if.out_ready        = 1'b1;

        #12;
        checks++;
        assert ({tx_if.out_byte, tx_if.out_valid, tx_if.out_eop, tx_if.get_tx_data,
                 tx_if.tx_busy, tx_if.tx_done} === 13'd0) else begin
            errors++;
            $error("FAIL reset_state: byte=%02h valid=%0b eop=%0b get=%0b busy=%0b done=%0b, expected all 0",
                   tx_if.out_byte, tx_if.out_valid, tx_if.out_eop, tx_if.get_tx_data,
                   tx_if.tx_busy, tx_if.tx_done);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;

        run_pkt("ack",   3'd3, 8'hD2, 1'b0, 7'd9,   0,  1'b0, 4,   -1);
        run_pkt("data0", 3'd1, 8'hC3, 1'b1, 7'd0,   0,  1'b0, 6,   -1);
        run_pkt("data1", 3'd2, 8'h4B, 1'b1, 7'd4,   4,  1'b1, -1,  -1);
        run_pkt("max64", 3'd1, 8'hC3, 1'b1, 7'd100, 64, 1'b0, 198, 20);
        run_pkt("stall", 3'd5, 8'h1E, 1'b0, 7'd0,   0,  1'b0, 4,   -1);

        ignored_start("code0_ignored", 3'd0);
        ignored_start("code7_ignored", 3'd7);

        // Reset while the second payload byte is on offer.
        g0 = get_cnt;
        push_expected(8'hC3, 1'b1, served, 5);
        tx_if.out_ready = 1'b1;
        start_strobe(3'd1, 7'd5);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk); #1;
            found = (get_cnt - g0 == 2) && (tx_if.out_valid === 1'b1);
        end
        checks++;
        assert (found === 1'b1) else begin
            errors++;
            $error("FAIL rst_reach_byte2: reached=%0b, expected 1", found);
        end
        #1;
        n_rst = 1'b0;
        #1;
        checks++;
        assert ({tx_if.out_byte, tx_if.out_valid, tx_if.out_eop, tx_if.get_tx_data,
                 tx_if.tx_busy, tx_if.tx_done} === 13'd0) else begin
            errors++;
            $error("FAIL rst_midpacket: byte=%02h valid=%0b eop=%0b get=%0b busy=%0b done=%0b, expected all 0",
                   tx_if.out_byte, tx_if.out_valid, tx_if.out_eop, tx_if.get_tx_data,
                   tx_if.tx_busy, tx_if.tx_done);
        end
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        assert (done_cnt === d0 && tx_if.tx_busy === 1'b0 && tx_if.out_eop === 1'b0) else begin
            errors++;
            $error("FAIL rst_no_done: done_pulses=%0d busy=%0b eop=%0b, expected 0 0 0",
                   done_cnt - d0, tx_if.tx_busy, tx_if.out_eop);
        end

        run_pkt("nak_after_rst", 3'd4, 8'h5A, 1'b0, 7'd0, 0, 1'b0, 4, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/usb_tx_packet_seq.md
# usb_tx_packet_seq

USB full-speed transmit packet sequencer. It sits downstream of the TX PID change detector and upstream of the bit-level NRZI/bit-stuff serializer. On a start strobe it emits the byte stream SYNC, PID, optional payload drawn from the TX data buffer, and CRC16, then requests EOP. All byte transfers to the serializer use a valid/ready handshake.

## Interface
- MAX_BYTES, default 64: maximum payload bytes per DATA packet.
- clk  in  1  system clock.
- n_rst  in  1  reset: asynchronous, active-low.
- tx_start  in  1  one-cycle strobe: a new packet request is pending on tx_packet.
- tx_packet  in  3  packet code: 0 NONE, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL; 6–7 invalid.
- buffer_occupancy  in  7  payload bytes available in the TX buffer; sampled on accepted start.
- get_tx_data  out  1  one-cycle buffer read request.
- tx_data  in  8  buffer byte; valid the cycle after get_tx_data.
- out_byte  out  8  byte to the serializer.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  serializer accepts the byte. Transfer occurs when out_valid && out_ready.
- out_eop  out  1  EOP request; held until out_ready.
- tx_busy  out  1  a packet is in progress.
- tx_done  out  1  one-cycle pulse after EOP is accepted.

## Operation
- States: IDLE, SYNC, PID, DATA_REQ, DATA_WAIT, DATA, CRC_LO, CRC_HI, EOP, DONE.
- IDLE → SYNC on tx_start with a valid code (1–5). Codes NONE and 6–7 are ignored and the block stays in IDLE. At acceptance it latches tx_packet and the byte count min(buffer_occupancy, MAX_BYTES).
- SYNC: out_byte=0x80. PID: out_byte is 0xC3 for DATA0, 0x4B for DATA1, 0xD2 for ACK, 0x5A for NAK, 0x1E for STALL.
- After the PID transfer:
  - ACK/NAK/STALL → EOP.
  - DATA with count>0 → DATA_REQ.
  - DATA with count=0 → CRC_LO.
- DATA_REQ asserts get_tx_data for exactly one cycle, then goes to DATA_WAIT. DATA_WAIT captures tx_data into out_byte, updates the CRC, decrements the count, and goes to DATA. DATA holds out_valid until transfer, then goes to DATA_REQ if count>0, otherwise CRC_LO.
- CRC16 (USB): polynomial 0x8005, init 0xFFFF, bytes processed LSB-first. The transmitted value is the one's complement, low byte in CRC_LO, high byte in CRC_HI. The CRC is cleared on start acceptance.
- EOP: out_valid=0, out_eop=1 until out_ready, then DONE. DONE pulses tx_done and returns to IDLE.
- tx_busy=1 in every state except IDLE. tx_start while busy is ignored and does not queue.
- out_byte and out_valid stay stable while out_valid && !out_ready. out_valid=0 in IDLE, DATA_REQ, DATA_WAIT, EOP and DONE.
- Reset mid-packet: immediate return to IDLE with all outputs at reset values. No EOP or tx_done is issued.

## Timing
- Reset values: out_byte=0, out_valid=0, out_eop=0, get_tx_data=0, tx_busy=0, tx_done=0, state IDLE, count 0, CRC 0xFFFF.
- tx_start in cycle N → out_valid=1 with 0x80 in N+1.
- With out_ready tied high:
  - Handshake packet: 2 byte cycles, 1 EOP cycle, tx_done 1 cycle after the EOP is accepted.
  - DATA packet with k bytes: SYNC(1) + PID(1) + 3k + CRC(2) + EOP(1) + DONE(1) cycles.
- All outputs are registered. get_tx_data is never asserted outside DATA_REQ.

## Structure
- Package usb_pkg holds:
  - the tx_packet_t enum;
  - PID byte constants and SYNC_BYTE;
  - CRC16_POLY, CRC16_INIT;
  - the state enum.
- Sub-module usb_crc16_byte: 16-bit CRC register with clear and byte-enable ports, combinational 8-step update, asynchronous reset to 0xFFFF.

## Test plan
- ACK request, out_ready=1 → bytes 0x80, 0xD2, then out_eop=1 for 1 cycle, tx_done pulse. get_tx_data never asserted.
- DATA0 with buffer_occupancy=0 → bytes 0x80, 0xC3, 0x00, 0x00, then EOP, tx_done.
- DATA1 with 4 bytes 0x00–0x03 and out_ready toggling 1/0 → bytes 0x80, 0x4B, 00, 01, 02, 03, then CRC matching the golden model. Each byte stays stable through stalls, with exactly 4 get_tx_data pulses.
- buffer_occupancy=100 with MAX_BYTES=64 → exactly 64 payload bytes and 64 reads.
- tx_start while busy, and tx_start with code 0 or 7 → both ignored. The current packet is unchanged and IDLE is held respectively.
- n_rst asserted during payload byte 2 → all outputs 0 immediately, no tx_done. A fresh NAK request afterwards produces 0x80, 0x5A, EOP.
